pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Controller that feeds a serial bit-pattern detector from a parallel word stream and accounts for its detections. Accepts 8-bit words over a valid/ready handshake and serializes them MSB-first. Each bit runs through a programmable overlapping pattern matcher of length 1–8. Matches are counted with saturation and raise a sticky threshold interrupt. Sits between the word-level producer and the serial detection path; owns pattern configuration for that path.

## Interface
- CNT_W, 8, width of match counter and threshold
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  configuration write strobe; honoured only while idle
- cfg_pattern  in  8  pattern bits; pattern occupies the low cfg_len bits, MSB of that field is detected first
- cfg_len  in  4  pattern length; 0 disables matching, 9–15 clamp to 8
- cfg_thresh  in  CNT_W  interrupt threshold; 0 disables irq
- in_valid  in  1  input word valid
- in_data  in  8  input word
- in_ready  out  1  block can accept a word this cycle
- bit_out  out  1  current serialized bit
- bit_valid  out  1  bit_out is valid this cycle
- match  out  1  one-cycle detection pulse
- match_count  out  CNT_W  saturating detection count
- irq  out  1  sticky threshold interrupt
- irq_clr  in  1  clears irq
- busy  out  1  serialization in progress

## Operation
- FSM states:
  - IDLE: in_ready=1, bit_valid=0. in_valid&in_ready captures in_data into the shift register, sets bit index 0, and goes to SHIFT.
  - SHIFT: bit_valid=1, bit_out=shift_reg[7], busy=1. Shift left each cycle and increment the index.
  - At index 7, in_ready=1. If a word is accepted there, reload and stay in SHIFT at index 0. Otherwise return to IDLE.
- Matcher:
  - On every valid bit, hist <= {hist[6:0], bit_out}.
  - seen (4-bit) increments, saturating at 8.
  - A hit occurs when seen+1 >= L, L != 0, and the low L bits of {hist[6:0],bit_out} equal the low L bits of the pattern.
- Matches overlap; history is never cleared on a match. History persists across words and idle gaps.
- On a hit, match is registered high for exactly the next cycle (Moore-style). match_count increments the same edge, saturating at 2^CNT_W−1.
- irq sets on the edge where match_count becomes equal to thresh (thresh != 0). It stays set until irq_clr. Simultaneous set and irq_clr: set wins.
- cfg_we in IDLE:
  - Loads pattern, len, and thresh.
  - Clears hist, seen, match_count, and irq.
- cfg_we in SHIFT is ignored entirely.
- Configuration reset values: pattern 8'h0B, len 4 (detects 1011), thresh 0.

## Timing
- Reset (asynchronous, active-low):
  - FSM→IDLE; shift_reg, hist, seen, match_count → 0.
  - bit_out=0, bit_valid=0, match=0, irq=0, busy=0.
  - in_ready=1 (combinational from IDLE).
- Reset mid-word drops the remaining bits; no match is reported for them.
- Handshake at edge t: bit k of the word drives bit_out during cycle t+1+k, k=0..7.
- A hit on bit k shows match=1 during cycle t+2+k.
- Back-to-back acceptance at index 7 gives an unbroken bit_valid stream with no bubble.
- in_ready is combinational from state/index only, never from in_valid.
- Throughput: one word per 8 cycles. Latency from handshake to first bit is 1 cycle.
- match_count and irq update on the same edge that match rises.

## Test plan
- Default config; one word 8'hB6 (1,0,1,1,0,1,1,0) accepted at t -> bit_valid t+1..t+8; match pulses in cycles t+5 and t+8 (overlap); match_count=2; in_ready low t+1..t+7.
- Cross-word history: words 8'h01 then 8'h60 back-to-back -> bit_valid continuous for 16 cycles; exactly one match, on second word bit 2; match_count=1.
- Config cfg_pattern=8'h01, cfg_len=1, cfg_thresh=3; send 8'hFF -> match every bit cycle; irq rises on third match; count ends at 8. irq_clr then reasserts nothing; irq_clr on the edge irq sets -> irq stays 1.
- Saturation: len 1, pattern 1, thirty-two 8'hFF words -> match_count reaches 255 and holds; match keeps pulsing.
- cfg_we during SHIFT with len=0 -> ignored; matches continue under old pattern. Repeat in IDLE -> count and irq cleared; no further matches.
- Assert reset at the 4th bit of 8'hB6 -> all outputs at reset values immediately. After release, in_ready=1 and the next word is serialized from bit 0 with empty history.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit serializer feeding an overlapping programmable pattern matcher,
// with a saturating match counter and a sticky threshold interrupt.
module pattern_scan_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we_i,
  input  logic [7:0]       cfg_pattern_i,
  input  logic [3:0]       cfg_len_i,
  input  logic [CNT_W-1:0] cfg_thresh_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             bit_out_o,
  output logic             bit_valid_o,
  output logic             match_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic             irq_o,
  input  logic             irq_clr_i,
  output logic             busy_o
);

  localparam int unsigned WORD_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned HIST_W = WORD_W - 1;

  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [WORD_W-1:0] RST_PAT  = 8'h0B;
  localparam logic [LEN_W-1:0] RST_LEN   = 4'd4;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]    seen_q, seen_d;
  logic                match_q, match_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                irq_q, irq_d;
  logic [WORD_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    thresh_q, thresh_d;

  logic                in_ready_c;
  logic                hit_c;
  logic [WORD_W-1:0]   window_c;
  logic [WORD_W-1:0]   len_mask_c;

  // Current bit joins the history; the low len bits must equal the pattern field.
  always_comb begin
    window_c   = {hist_q, shift_q[WORD_W-1]};
    len_mask_c = 8'hFF >> (MAX_LEN - len_q);
    hit_c      = (len_q != '0)
              && ((5'(seen_q) + 5'd1) >= 5'(len_q))
              && ((window_c & len_mask_c) == (pat_q & len_mask_c));
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    hist_d     = hist_q;
    seen_d     = seen_q;
    match_d    = 1'b0;
    count_d    = count_q;
    irq_d      = irq_q;
    pat_d      = pat_q;
    len_d      = len_q;
    thresh_d   = thresh_q;
    in_ready_c = 1'b0;

    if (irq_clr_i) begin
      irq_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid_i) begin
          shift_d = in_data_i;
          idx_d   = '0;
          state_d = SHIFT;
        end
        if (cfg_we_i) begin
          pat_d    = cfg_pattern_i;
          len_d    = (cfg_len_i > MAX_LEN) ? MAX_LEN : cfg_len_i;
          thresh_d = cfg_thresh_i;
          hist_d   = '0;
          seen_d   = '0;
          count_d  = '0;
          irq_d    = 1'b0;
        end
      end

      SHIFT: begin
        shift_d = {shift_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q + IDX_W'(1);
        hist_d  = window_c[HIST_W-1:0];
        seen_d  = (seen_q >= MAX_LEN) ? seen_q : seen_q + LEN_W'(1);
        match_d = hit_c;
        // Interrupt fires only on the edge the count steps onto the threshold.
        if (hit_c && (count_q != CNT_MAX)) begin
          count_d = count_q + CNT_W'(1);
          if ((thresh_q != '0) && (count_d == thresh_q)) begin
            irq_d = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          in_ready_c = 1'b1;
          if (in_valid_i) begin
            shift_d = in_data_i;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      hist_q   <= '0;
      seen_q   <= '0;
      match_q  <= 1'b0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      pat_q    <= RST_PAT;
      len_q    <= RST_LEN;
      thresh_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      hist_q   <= hist_d;
      seen_q   <= seen_d;
      match_q  <= match_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      thresh_q <= thresh_d;
    end
  end

  assign in_ready_o    = in_ready_c;
  assign bit_out_o     = shift_q[WORD_W-1];
  assign bit_valid_o   = (state_q == SHIFT);
  assign busy_o        = (state_q == SHIFT);
  assign match_o       = match_q;
  assign match_count_o = count_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: expected bits queued at each handshake,
// popped and scored per cycle against a reference matcher on the expected stream.
module tb_pattern_scan_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_we_i = 1'b0;
  logic [7:0]       cfg_pattern_i = '0;
  logic [3:0]       cfg_len_i = '0;
  logic [CNT_W-1:0] cfg_thresh_i = '0;
  logic             in_valid_i = 1'b0;
  logic [7:0]       in_data_i = '0;
  logic             in_ready_o;
  logic             bit_out_o;
  logic             bit_valid_o;
  logic             match_o;
  logic [CNT_W-1:0] match_count_o;
  logic             irq_o;
  logic             irq_clr_i = 1'b0;
  logic             busy_o;

  pattern_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we_i      (cfg_we_i),
    .cfg_pattern_i (cfg_pattern_i),
    .cfg_len_i     (cfg_len_i),
    .cfg_thresh_i  (cfg_thresh_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .bit_out_o     (bit_out_o),
    .bit_valid_o   (bit_valid_o),
    .match_o       (match_o),
    .match_count_o (match_count_o),
    .irq_o         (irq_o),
    .irq_clr_i     (irq_clr_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and reference-model state
  logic       bitq[$];
  bit         mh[$];
  logic [7:0] m_pat = 8'h0B;
  int         m_len = 4;
  int         m_thr = 0;
  int         m_cnt = 0;
  bit         m_irq = 1'b0;
  bit         m_nx = 1'b0;
  bit         cfg_expect = 1'b0;
  int         bv_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit();
    if (m_len == 0 || mh.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (mh[mh.size()-1-i] !== m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Per-cycle monitor: compare what the DUT shows now, then advance the model.
  always @(negedge clk) begin
    bit   hit;
    logic eb;
    if (!rst_n) begin
      bitq.delete();
      mh.delete();
      m_pat = 8'h0B; m_len = 4; m_thr = 0;
      m_cnt = 0; m_irq = 1'b0; m_nx = 1'b0;
    end else begin
      chk("match", match_o, m_nx);
      chk("match_count", match_count_o, m_cnt);
      chk("irq", irq_o, m_irq);
      hit = 1'b0;
      if (bitq.size() == 0) begin
        chk("spurious_bit_valid", bit_valid_o, 0);
      end else if (bit_valid_o) begin
        bv_cycles++;
        eb = bitq.pop_front();
        chk("bit_out", bit_out_o, eb);
        mh.push_back(eb);
        if (mh.size() > 8) void'(mh.pop_front());
        hit = model_hit();
      end
      m_nx = hit;
      if (hit && m_cnt != 255) begin
        m_cnt++;
        if (m_thr != 0 && m_cnt == m_thr) m_irq = 1'b1;
        else if (irq_clr_i) m_irq = 1'b0;
      end else if (irq_clr_i) begin
        m_irq = 1'b0;
      end
      if (cfg_we_i && cfg_expect) begin
        m_pat = cfg_pattern_i;
        m_len = (cfg_len_i > 4'd8) ? 8 : int'(cfg_len_i);
        m_thr = int'(cfg_thresh_i);
        m_cnt = 0; m_irq = 1'b0;
        mh.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, output int t);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    while (!in_ready_o && n < 20) begin step(); n++; end
    if (n >= 20) chk("send_timeout_in_ready", in_ready_o, 1);
    @(posedge clk);
    for (int k = 7; k >= 0; k--) bitq.push_back(d[k]);
    #1;
    t = cyc;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((bitq.size() != 0 || bit_valid_o) && n < 400) begin step(); n++; end
    if (n >= 400) chk("drain_timeout_bit_valid", bit_valid_o, 0);
    step(); step();
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] th,
                     input bit honour);
    cfg_pattern_i = p; cfg_len_i = l; cfg_thresh_i = th;
    cfg_we_i = 1'b1; cfg_expect = honour;
    step();
    cfg_we_i = 1'b0; cfg_expect = 1'b0;
  endtask

  initial begin
    int t, t1, t2;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_bit_valid", bit_valid_o, 0);
    chk("rst_bit_out", bit_out_o, 0);
    chk("rst_match", match_o, 0);
    chk("rst_count", match_count_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_busy", busy_o, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Default 1011 pattern on B6: matches on bits 3 and 6 with overlap
    send(8'hB6, t);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("b6_in_ready_k%0d", k), in_ready_o, (k == 8) ? 1 : 0);
      chk($sformatf("b6_bit_valid_k%0d", k), bit_valid_o, 1);
      chk($sformatf("b6_busy_k%0d", k), busy_o, 1);
      step();
    end
    chk("b6_bit_valid_after", bit_valid_o, 0);
    chk("b6_in_ready_after", in_ready_o, 1);
    drain();
    chk("b6_count", match_count_o, 2);

    // History carries across back-to-back words
    cfg(8'h0B, 4'd4, 8'd0, 1'b1);
    bv_cycles = 0;
    send(8'h01, t1);
    send(8'h60, t2);
    chk("b2b_spacing", t2 - t1, 8);
    drain();
    chk("b2b_bit_valid_cycles", bv_cycles, 16);
    chk("b2b_count", match_count_o, 1);

    // len 1, threshold 3; then irq_clr; then clear coinciding with set
    cfg(8'h01, 4'd1, 8'd3, 1'b1);
    send(8'hFF, t);
    drain();
    chk("thr_count", match_count_o, 8);
    chk("thr_irq", irq_o, 1);
    irq_clr_i = 1'b1; step(); irq_clr_i = 1'b0;
    chk("irq_cleared", irq_o, 0);
    step();
    chk("irq_stays_clear", irq_o, 0);
    cfg(8'h01, 4'd1, 8'd3, 1'b1);
    send(8'hFF, t);
    step(); step();
    irq_clr_i = 1'b1; step(); irq_clr_i = 1'b0;
    chk("irq_set_wins", irq_o, 1);
    drain();
    chk("irq_set_wins_hold", irq_o, 1);

    // Saturation with 32 back-to-back FF words
    cfg(8'h01, 4'd1, 8'd0, 1'b1);
    for (int w = 0; w < 32; w++) send(8'hFF, t);
    drain();
    chk("sat_count", match_count_o, 255);

    // Config during SHIFT ignored; in IDLE applied (len 0 disables)
    cfg(8'h01, 4'd1, 8'd2, 1'b1);
    send(8'hFF, t);
    cfg(8'h00, 4'd0, 8'd0, 1'b0);
    drain();
    chk("shift_cfg_ignored_count", match_count_o, 8);
    chk("shift_cfg_ignored_irq", irq_o, 1);
    cfg(8'h00, 4'd0, 8'd0, 1'b1);
    chk("idle_cfg_count", match_count_o, 0);
    chk("idle_cfg_irq", irq_o, 0);
    send(8'hFF, t);
    drain();
    chk("len0_no_match_count", match_count_o, 0);

    // Reset while the 4th bit of B6 is on the wire
    cfg(8'h0B, 4'd4, 8'd0, 1'b1);
    send(8'hB6, t);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready_o, 1);
    chk("mid_rst_bit_valid", bit_valid_o, 0);
    chk("mid_rst_bit_out", bit_out_o, 0);
    chk("mid_rst_match", match_o, 0);
    chk("mid_rst_count", match_count_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready_o, 1);
    send(8'hB6, t);
    drain();
    chk("post_rst_count", match_count_o, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
